// File: rtl/axis_sample_fifo_16.sv
// First-word-fall-through AXI-stream FIFO for 16-bit ECG samples feeding the width adapter.
// Samples offered while the FIFO is full are lost, and overflow_cnt counts them.
module axis_sample_fifo_16 #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [15:0]       s_axis_tdata,
    input  logic              s_axis_tvalid,
    output logic              s_axis_tready,
    output logic [15:0]       m_axis_tdata,
    output logic              m_axis_tvalid,
    input  logic              m_axis_tready,
    output logic [ADDR_W:0]   fill_level,
    output logic [15:0]       overflow_cnt,
    input  logic              clear_overflow
);

    localparam logic [ADDR_W:0] FULL_LEVEL = (ADDR_W + 1)'(DEPTH);

    logic [15:0]       mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [ADDR_W:0]   fill_next;
    logic              wr_en;
    logic              rd_en;
    logic              drop;

    assign wr_en         = s_axis_tvalid && s_axis_tready;
    assign rd_en         = m_axis_tvalid && m_axis_tready;
    assign drop          = s_axis_tvalid && !s_axis_tready;
    assign m_axis_tvalid = (fill_level != '0);
    assign m_axis_tdata  = mem[rd_ptr];

    always_comb begin
        fill_next = fill_level;
        if (wr_en && !rd_en) begin
            fill_next = fill_level + 1'b1;
        end else if (rd_en && !wr_en) begin
            fill_next = fill_level - 1'b1;
        end
    end

    // Storage is cleared on reset so the stale head reads as zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_en) begin
            mem[wr_ptr] <= s_axis_tdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            fill_level    <= '0;
            s_axis_tready <= 1'b0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            fill_level    <= fill_next;
            // Registered ready: a slot freed by a read in the full cycle opens next cycle.
            s_axis_tready <= (fill_next != FULL_LEVEL);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow_cnt <= '0;
        end else if (clear_overflow) begin
            overflow_cnt <= '0;
        end else if (drop && (overflow_cnt != 16'hFFFF)) begin
            overflow_cnt <= overflow_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_axis_sample_fifo_16.sv
// Directed bench for axis_sample_fifo_16: reset, fill/drain, wrap, full+read, saturation, async reset.
module tb_axis_sample_fifo_16;

    logic        clk;
    logic        rst_n;
    logic [15:0] s_axis_tdata;
    logic        s_axis_tvalid;
    logic        s_axis_tready;
    logic [15:0] m_axis_tdata;
    logic        m_axis_tvalid;
    logic        m_axis_tready;
    logic [4:0]  fill_level;
    logic [15:0] overflow_cnt;
    logic        clear_overflow;

    int total = 0;
    int bad   = 0;

    axis_sample_fifo_16 #(.DEPTH(16), .ADDR_W(4)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .s_axis_tdata   (s_axis_tdata),
        .s_axis_tvalid  (s_axis_tvalid),
        .s_axis_tready  (s_axis_tready),
        .m_axis_tdata   (m_axis_tdata),
        .m_axis_tvalid  (m_axis_tvalid),
        .m_axis_tready  (m_axis_tready),
        .fill_level     (fill_level),
        .overflow_cnt   (overflow_cnt),
        .clear_overflow (clear_overflow)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_n          = 1'b0;
        s_axis_tdata   = '0;
        s_axis_tvalid  = 1'b0;
        m_axis_tready  = 1'b0;
        clear_overflow = 1'b0;

        // reset state
        #22;
        check("rst_s_tready", 32'(s_axis_tready), 32'd0);
        check("rst_m_tvalid", 32'(m_axis_tvalid), 32'd0);
        check("rst_m_tdata",  32'(m_axis_tdata),  32'd0);
        check("rst_fill",     32'(fill_level),    32'd0);
        check("rst_ovf",      32'(overflow_cnt),  32'd0);
        rst_n = 1'b1;

        // single write after reset release
        step();
        check("rel_s_tready", 32'(s_axis_tready), 32'd1);
        s_axis_tdata  = 16'h8001;
        s_axis_tvalid = 1'b1;
        step();
        s_axis_tvalid = 1'b0;
        check("single_tvalid", 32'(m_axis_tvalid), 32'd1);
        check("single_tdata",  32'(m_axis_tdata),  32'h8001);
        check("single_fill",   32'(fill_level),    32'd1);
        m_axis_tready = 1'b1;
        step();
        m_axis_tready = 1'b0;
        check("single_drained", 32'(m_axis_tvalid), 32'd0);

        // fill to full, overflow for 3 cycles, drain in order
        for (int i = 0; i < 16; i++) begin
            s_axis_tdata  = 16'(i);
            s_axis_tvalid = 1'b1;
            step();
        end
        check("full_fill",     32'(fill_level),    32'd16);
        check("full_s_tready", 32'(s_axis_tready), 32'd0);
        s_axis_tdata = 16'd16;
        repeat (3) step();
        s_axis_tvalid = 1'b0;
        check("full_ovf3", 32'(overflow_cnt), 32'd3);
        m_axis_tready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            check("drain_tvalid", 32'(m_axis_tvalid), 32'd1);
            check("drain_tdata",  32'(m_axis_tdata),  32'(i));
            step();
        end
        m_axis_tready = 1'b0;
        check("drain_empty_tvalid", 32'(m_axis_tvalid), 32'd0);
        check("drain_empty_fill",   32'(fill_level),    32'd0);

        clear_overflow = 1'b1;
        step();
        clear_overflow = 1'b0;
        check("clear_ovf", 32'(overflow_cnt), 32'd0);

        // level 5, then 40 cycles of simultaneous read/write across the wrap
        for (int i = 0; i < 5; i++) begin
            s_axis_tdata  = 16'(50 + i);
            s_axis_tvalid = 1'b1;
            step();
        end
        check("lvl5_fill", 32'(fill_level), 32'd5);
        m_axis_tready = 1'b1;
        for (int i = 0; i < 40; i++) begin
            s_axis_tdata = 16'(100 + i);
            check("rw_tdata", 32'(m_axis_tdata), (i < 5) ? 32'(50 + i) : 32'(100 + i - 5));
            step();
            check("rw_fill", 32'(fill_level), 32'd5);
        end
        s_axis_tvalid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check("rw_tail", 32'(m_axis_tdata), 32'(135 + i));
            step();
        end
        m_axis_tready = 1'b0;
        check("rw_empty", 32'(fill_level), 32'd0);

        // full with a one-cycle read while upstream keeps offering
        for (int i = 0; i < 16; i++) begin
            s_axis_tdata  = 16'(200 + i);
            s_axis_tvalid = 1'b1;
            step();
        end
        check("fr_full", 32'(fill_level), 32'd16);
        s_axis_tdata  = 16'hBEEF;
        m_axis_tready = 1'b1;
        step();
        m_axis_tready = 1'b0;
        s_axis_tvalid = 1'b0;
        check("fr_fill15",   32'(fill_level),    32'd15);
        check("fr_s_tready", 32'(s_axis_tready), 32'd1);
        check("fr_ovf",      32'(overflow_cnt),  32'd1);
        check("fr_head",     32'(m_axis_tdata),  32'd201);
        s_axis_tdata  = 16'd216;
        s_axis_tvalid = 1'b1;
        step();
        check("fr_refull",  32'(fill_level),    32'd16);
        check("fr_tready0", 32'(s_axis_tready), 32'd0);

        // saturation then clear while still overflowing
        repeat (70000) @(posedge clk);
        #1;
        check("sat_ovf", 32'(overflow_cnt), 32'hFFFF);
        check("sat_head_stable", 32'(m_axis_tdata), 32'd201);
        clear_overflow = 1'b1;
        step();
        clear_overflow = 1'b0;
        check("sat_clear", 32'(overflow_cnt), 32'd0);
        step();
        check("sat_resume", 32'(overflow_cnt), 32'd1);
        s_axis_tvalid = 1'b0;

        // drain to level 7, then asynchronous reset between edges
        m_axis_tready = 1'b1;
        repeat (9) step();
        m_axis_tready = 1'b0;
        check("mr_fill7", 32'(fill_level), 32'd7);
        #2;
        rst_n = 1'b0;
        #1;
        check("mr_tvalid", 32'(m_axis_tvalid), 32'd0);
        check("mr_fill",   32'(fill_level),    32'd0);
        check("mr_tready", 32'(s_axis_tready), 32'd0);
        check("mr_ovf",    32'(overflow_cnt),  32'd0);
        rst_n = 1'b1;
        step();
        check("mr_rel_tready", 32'(s_axis_tready), 32'd1);
        s_axis_tdata  = 16'h1234;
        s_axis_tvalid = 1'b1;
        step();
        s_axis_tdata = 16'h5678;
        step();
        s_axis_tvalid = 1'b0;
        check("mr_first_out", 32'(m_axis_tdata), 32'h1234);
        check("mr_fill2",     32'(fill_level),   32'd2);
        m_axis_tready = 1'b1;
        step();
        check("mr_second_out", 32'(m_axis_tdata), 32'h5678);
        step();
        m_axis_tready = 1'b0;
        check("mr_empty", 32'(fill_level), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
